// File: rtl/qmfir_pkg.sv
// QM-FIR shared types and constants.
// Read-tag encoding for the memory arbiter response path.
package qmfir_pkg;

  localparam int QMFIR_AW = 14;
  localparam int QMFIR_DW = 24;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_UART = 2'd1,
    TAG_FIR  = 2'd2
  } rd_tag_t;

endpackage

// File: rtl/qmfir_rd_tag_pipe.sv
// Read-tag shift register that tracks which requester owns
// each in-flight memory read.
module qmfir_rd_tag_pipe
  import qmfir_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    arst_n,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t stage_q [DEPTH];
  rd_tag_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = tag_i;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= TAG_NONE;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/qmfir_mem_arb.sv
// Single-port memory arbiter: FIR stream has priority, a
// starvation counter bounds how long a UART request can wait.
module qmfir_mem_arb
  import qmfir_pkg::*;
#(
  parameter int AW            = QMFIR_AW,
  parameter int DW            = QMFIR_DW,
  parameter int RD_LAT        = 1,
  parameter int MAX_FIR_BURST = 8
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic [AW-1:0] uart_addr,
  input  logic [DW-1:0] uart_dout,
  input  logic          uart_mem_we,
  input  logic          uart_mem_re,
  output logic [DW-1:0] uart_mem_din,
  output logic          uart_mem_rvalid,
  output logic          uart_busy,
  output logic          uart_req_drop,
  input  logic          fir_req,
  input  logic          fir_we,
  input  logic [AW-1:0] fir_addr,
  input  logic [DW-1:0] fir_wdata,
  output logic          fir_gnt,
  output logic [DW-1:0] fir_rdata,
  output logic          fir_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = (MAX_FIR_BURST > 0) ?
    $clog2(MAX_FIR_BURST + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_FIR_BURST);

  logic          pend_q, pend_d;
  logic [AW-1:0] ub_addr_q, ub_addr_d;
  logic [DW-1:0] ub_data_q, ub_data_d;
  logic          ub_we_q, ub_we_d;
  logic          drop_q, drop_d;
  logic [CW-1:0] starve_q, starve_d;

  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  logic          u_rv_q, u_rv_d;
  logic [DW-1:0] u_rd_q, u_rd_d;
  logic          f_rv_q, f_rv_d;
  logic [DW-1:0] f_rd_q, f_rd_d;

  logic          uart_pulse;
  logic          force_uart;
  logic          fir_issue;
  logic          uart_issue;
  rd_tag_t       tag_in;
  rd_tag_t       tag_out;

  assign uart_pulse = uart_mem_we | uart_mem_re;

  always_comb begin
    force_uart = pend_q & (starve_q == CMAX);
    fir_issue  = fir_req & ~force_uart;
    uart_issue = ~fir_issue & pend_q;

    pend_d    = pend_q;
    ub_addr_d = ub_addr_q;
    ub_data_d = ub_data_q;
    ub_we_d   = ub_we_q;
    drop_d    = 1'b0;
    if (uart_issue) pend_d = 1'b0;
    // Issuing frees the buffer in time to take a same-cycle pulse.
    if (uart_pulse) begin
      if (!pend_q || uart_issue) begin
        pend_d    = 1'b1;
        ub_addr_d = uart_addr;
        ub_data_d = uart_dout;
        ub_we_d   = uart_mem_we;
      end else begin
        drop_d = 1'b1;
      end
    end

    starve_d = starve_q;
    if (uart_issue || !pend_q) begin
      starve_d = '0;
    end else if (fir_issue && starve_q != CMAX) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    mem_en_d    = fir_issue | uart_issue;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tag_in      = TAG_NONE;
    unique case (1'b1)
      fir_issue: begin
        mem_we_d    = fir_we;
        mem_addr_d  = fir_addr;
        mem_wdata_d = fir_wdata;
        tag_in      = fir_we ? TAG_NONE : TAG_FIR;
      end
      uart_issue: begin
        mem_we_d    = ub_we_q;
        mem_addr_d  = ub_addr_q;
        mem_wdata_d = ub_data_q;
        tag_in      = ub_we_q ? TAG_NONE : TAG_UART;
      end
      default: ;
    endcase
  end

  always_comb begin
    u_rv_d = (tag_out == TAG_UART);
    f_rv_d = (tag_out == TAG_FIR);
    u_rd_d = u_rv_d ? mem_rdata : u_rd_q;
    f_rd_d = f_rv_d ? mem_rdata : f_rd_q;
  end

  qmfir_rd_tag_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_tag_pipe (
    .clk    (clk),
    .arst_n (arst_n),
    .tag_i  (tag_in),
    .tag_o  (tag_out)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pend_q      <= 1'b0;
      ub_addr_q   <= '0;
      ub_data_q   <= '0;
      ub_we_q     <= 1'b0;
      drop_q      <= 1'b0;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      u_rv_q      <= 1'b0;
      u_rd_q      <= '0;
      f_rv_q      <= 1'b0;
      f_rd_q      <= '0;
    end else begin
      pend_q      <= pend_d;
      ub_addr_q   <= ub_addr_d;
      ub_data_q   <= ub_data_d;
      ub_we_q     <= ub_we_d;
      drop_q      <= drop_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      u_rv_q      <= u_rv_d;
      u_rd_q      <= u_rd_d;
      f_rv_q      <= f_rv_d;
      f_rd_q      <= f_rd_d;
    end
  end

  assign fir_gnt         = ~force_uart;
  assign uart_busy       = pend_q;
  assign uart_req_drop   = drop_q;
  assign mem_en          = mem_en_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign uart_mem_rvalid = u_rv_q;
  assign uart_mem_din    = u_rd_q;
  assign fir_rvalid      = f_rv_q;
  assign fir_rdata       = f_rd_q;

endmodule

// File: tb/tb_qmfir_mem_arb.sv
// Bench for qmfir_mem_arb: RD_LAT=1 and RD_LAT=2 instances share
// stimulus and are checked against a transaction-level model.
module tb_qmfir_mem_arb;

  localparam int MAXB = 8;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [13:0] uart_addr = '0;
  logic [23:0] uart_dout = '0;
  logic        uart_mem_we = 1'b0;
  logic        uart_mem_re = 1'b0;
  logic        fir_req = 1'b0;
  logic        fir_we = 1'b0;
  logic [13:0] fir_addr = '0;
  logic [23:0] fir_wdata = '0;

  logic [23:0] udin1, frd1, mwd1, mrd1;
  logic [23:0] udin2, frd2, mwd2, mrd2;
  logic [13:0] mad1, mad2;
  logic urv1, busy1, drop1, gnt1, frv1, men1, mwe1;
  logic urv2, busy2, drop2, gnt2, frv2, men2, mwe2;

  int ntot = 0;
  int npass = 0;
  int cyc = 0;
  int nu1 = 0, nf1 = 0, nu2 = 0, nf2 = 0;

  always #5 clk = ~clk;

  qmfir_mem_arb #(.RD_LAT(1), .MAX_FIR_BURST(MAXB)) dut1 (
    .clk(clk), .arst_n(arst_n),
    .uart_addr(uart_addr), .uart_dout(uart_dout),
    .uart_mem_we(uart_mem_we), .uart_mem_re(uart_mem_re),
    .uart_mem_din(udin1), .uart_mem_rvalid(urv1),
    .uart_busy(busy1), .uart_req_drop(drop1),
    .fir_req(fir_req), .fir_we(fir_we), .fir_addr(fir_addr),
    .fir_wdata(fir_wdata), .fir_gnt(gnt1), .fir_rdata(frd1),
    .fir_rvalid(frv1), .mem_en(men1), .mem_we(mwe1),
    .mem_addr(mad1), .mem_wdata(mwd1), .mem_rdata(mrd1)
  );

  qmfir_mem_arb #(.RD_LAT(2), .MAX_FIR_BURST(MAXB)) dut2 (
    .clk(clk), .arst_n(arst_n),
    .uart_addr(uart_addr), .uart_dout(uart_dout),
    .uart_mem_we(uart_mem_we), .uart_mem_re(uart_mem_re),
    .uart_mem_din(udin2), .uart_mem_rvalid(urv2),
    .uart_busy(busy2), .uart_req_drop(drop2),
    .fir_req(fir_req), .fir_we(fir_we), .fir_addr(fir_addr),
    .fir_wdata(fir_wdata), .fir_gnt(gnt2), .fir_rdata(frd2),
    .fir_rvalid(frv2), .mem_en(men2), .mem_we(mwe2),
    .mem_addr(mad2), .mem_wdata(mwd2), .mem_rdata(mrd2)
  );

  function automatic logic [23:0] finit(input logic [13:0] a);
    logic [31:0] v;
    if (a == 14'h0010) return 24'h555AAA;
    v = ({18'd0, a} * 32'h0001F3B7) ^ 32'h00C3A5A5;
    return v[23:0];
  endfunction

  // Memories attached to each DUT, plus the model's own copy.
  logic [23:0] mem1 [int];
  logic [23:0] mem2 [int];
  logic [23:0] mmem [int];
  logic [23:0] r1a = '0, r2a = '0, r2b = '0;

  assign mrd1 = r1a;
  assign mrd2 = r2b;

  function automatic logic [23:0] rd1(input logic [13:0] a);
    return mem1.exists(int'(a)) ? mem1[int'(a)] : finit(a);
  endfunction
  function automatic logic [23:0] rd2(input logic [13:0] a);
    return mem2.exists(int'(a)) ? mem2[int'(a)] : finit(a);
  endfunction
  function automatic logic [23:0] rdm(input logic [13:0] a);
    return mmem.exists(int'(a)) ? mmem[int'(a)] : finit(a);
  endfunction

  initial forever begin
    @(posedge clk);
    if (men1) begin
      if (mwe1) mem1[int'(mad1)] = mwd1;
      else r1a <= rd1(mad1);
    end
    if (men2) begin
      if (mwe2) mem2[int'(mad2)] = mwd2;
      else r2a <= rd2(mad2);
    end
    r2b <= r2a;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Transaction-level model: request queue of one, priority with
  // burst limit, read responses scheduled by absolute cycle.
  typedef struct {
    int          t;
    bit          u;
    logic [23:0] d;
  } rsp_t;
  rsp_t q1[$];
  rsp_t q2[$];

  bit          m_pend = 0;
  int          m_cnt = 0;
  logic [13:0] m_addr = '0;
  logic [23:0] m_data = '0;
  bit          m_we = 0;
  bit          e_en = 0, e_we = 0, e_drop = 0;
  bit          e_gnt = 1, e_busy = 0;
  logic [13:0] e_addr = '0;
  logic [23:0] e_wdata = '0;

  initial forever begin
    int t;
    bit fi, ui, pulse, old_pend, g;
    logic [23:0] d;
    @(posedge clk or negedge arst_n);
    if (!arst_n) begin
      m_pend = 0; m_cnt = 0;
      e_en = 0; e_we = 0; e_drop = 0;
      e_gnt = 1; e_busy = 0;
      q1.delete(); q2.delete();
    end else begin
      t = cyc;
      cyc++;
      g = !(m_pend && m_cnt == MAXB);
      fi = fir_req && g;
      ui = !fi && m_pend;
      pulse = uart_mem_we || uart_mem_re;
      e_en = fi || ui;
      e_we = 0;
      if (fi) begin
        e_we = fir_we; e_addr = fir_addr; e_wdata = fir_wdata;
      end else if (ui) begin
        e_we = m_we; e_addr = m_addr; e_wdata = m_data;
      end
      if (e_en) begin
        if (e_we) mmem[int'(e_addr)] = e_wdata;
        else begin
          d = rdm(e_addr);
          q1.push_back('{t + 3, ui, d});
          q2.push_back('{t + 4, ui, d});
        end
      end
      e_drop = pulse && m_pend && !ui;
      old_pend = m_pend;
      if (ui) m_pend = 0;
      if (pulse && !e_drop) begin
        m_pend = 1; m_addr = uart_addr;
        m_data = uart_dout; m_we = uart_mem_we;
      end
      if (ui || !old_pend) m_cnt = 0;
      else if (fi && m_cnt < MAXB) m_cnt++;
      e_busy = m_pend;
      e_gnt = !(m_pend && m_cnt == MAXB);
    end
  end

  task automatic cmp_cmd(input string p, input logic en,
                         input logic we, input logic [13:0] a,
                         input logic [23:0] wd, input logic gt,
                         input logic bz, input logic dr);
    chk({p, "mem_en"}, 32'(en), 32'(e_en));
    chk({p, "mem_we"}, 32'(we), 32'(e_we));
    if (e_en) chk({p, "mem_addr"}, 32'(a), 32'(e_addr));
    if (e_en && e_we) chk({p, "mem_wdata"}, 32'(wd), 32'(e_wdata));
    chk({p, "fir_gnt"}, 32'(gt), 32'(e_gnt));
    chk({p, "uart_busy"}, 32'(bz), 32'(e_busy));
    chk({p, "uart_req_drop"}, 32'(dr), 32'(e_drop));
  endtask

  initial forever begin
    @(negedge clk);
    cmp_cmd("d1.", men1, mwe1, mad1, mwd1, gnt1, busy1, drop1);
    cmp_cmd("d2.", men2, mwe2, mad2, mwd2, gnt2, busy2, drop2);
    if (q1.size() > 0 && q1[0].t == cyc) begin
      chk("d1.uart_rvalid", 32'(urv1), 32'(q1[0].u));
      chk("d1.fir_rvalid", 32'(frv1), 32'(!q1[0].u));
      if (q1[0].u) chk("d1.uart_din", 32'(udin1), 32'(q1[0].d));
      else chk("d1.fir_rdata", 32'(frd1), 32'(q1[0].d));
      void'(q1.pop_front());
    end else begin
      chk("d1.uart_rvalid", 32'(urv1), 0);
      chk("d1.fir_rvalid", 32'(frv1), 0);
    end
    if (q2.size() > 0 && q2[0].t == cyc) begin
      chk("d2.uart_rvalid", 32'(urv2), 32'(q2[0].u));
      chk("d2.fir_rvalid", 32'(frv2), 32'(!q2[0].u));
      if (q2[0].u) chk("d2.uart_din", 32'(udin2), 32'(q2[0].d));
      else chk("d2.fir_rdata", 32'(frd2), 32'(q2[0].d));
      void'(q2.pop_front());
    end else begin
      chk("d2.uart_rvalid", 32'(urv2), 0);
      chk("d2.fir_rvalid", 32'(frv2), 0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (urv1) nu1++;
    if (frv1) nf1++;
    if (urv2) nu2++;
    if (frv2) nf2++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (fir_req) fir_addr = fir_addr + 14'd1;
  endtask

  initial begin
    int nfir, gap, su1, sf1, su2, sf2;
    // Reset state
    tick(); tick();
    chk("rst.mem_en", 32'(men1), 0);
    chk("rst.fir_gnt", 32'(gnt1), 1);
    chk("rst.uart_busy", 32'(busy1), 0);
    chk("rst.rvalid", 32'({urv1, frv1, drop1}), 0);
    arst_n = 1'b1;
    tick(); tick();

    // UART write, FIR idle
    uart_mem_we = 1; uart_addr = 14'h0123; uart_dout = 24'hABCDEF;
    tick();
    uart_mem_we = 0;
    chk("uwr.busy_t1", 32'(busy1), 1);
    chk("uwr.men_t1", 32'(men1), 0);
    tick();
    chk("uwr.men_t2", 32'(men1), 1);
    chk("uwr.mwe_t2", 32'(mwe1), 1);
    chk("uwr.addr_t2", 32'(mad1), 32'h0123);
    chk("uwr.wdata_t2", 32'(mwd1), 32'hABCDEF);
    chk("uwr.busy_t2", 32'(busy1), 0);
    tick(); tick();

    // UART read of 0x0010
    uart_mem_re = 1; uart_addr = 14'h0010;
    tick();
    uart_mem_re = 0;
    tick(); tick();
    chk("urd.rvalid_t3", 32'(urv1), 0);
    tick();
    chk("urd.rvalid_t4", 32'(urv1), 1);
    chk("urd.din_t4", 32'(udin1), 32'h555AAA);
    chk("urd.fir_rvalid_t4", 32'(frv1), 0);
    tick();
    chk("urd.rvalid_t5", 32'(urv1), 0);
    tick(); tick();

    // FIR continuous reads with a UART write waiting
    fir_req = 1; fir_we = 0; fir_addr = 14'h0200;
    tick(); tick(); tick();
    uart_mem_we = 1; uart_addr = 14'h0300; uart_dout = 24'h123456;
    tick();
    uart_mem_we = 0;
    nfir = 0; gap = -1;
    for (int k = 0; k < 30; k++) begin
      if (gnt1) nfir++;
      else begin
        gap = k;
        break;
      end
      tick();
    end
    chk("burst.fir_issues", 32'(nfir), 8);
    chk("burst.gnt_low_at", 32'(gap), 8);
    tick();
    chk("burst.gnt_back", 32'(gnt1), 1);
    chk("burst.men", 32'(men1), 1);
    chk("burst.mwe", 32'(mwe1), 1);
    chk("burst.addr", 32'(mad1), 32'h0300);
    chk("burst.wdata", 32'(mwd1), 32'h123456);

    // Second pulse while pending under FIR load is dropped
    uart_mem_we = 1; uart_addr = 14'h0400; uart_dout = 24'h111111;
    tick();
    uart_mem_we = 0;
    tick();
    uart_mem_we = 1; uart_addr = 14'h0401; uart_dout = 24'h222222;
    tick();
    uart_mem_we = 0;
    chk("drop.strobe", 32'(drop1), 1);
    chk("drop.busy", 32'(busy1), 1);
    tick();
    chk("drop.strobe_end", 32'(drop1), 0);
    for (int k = 0; k < 10; k++) tick();
    fir_req = 0;
    tick(); tick(); tick(); tick();
    chk("drop.mem1_first", 32'(rd1(14'h0400)), 32'h111111);
    chk("drop.mem1_second", 32'(rd1(14'h0401)),
        32'(finit(14'h0401)));
    chk("drop.mem2_second", 32'(rd2(14'h0401)),
        32'(finit(14'h0401)));

    // Interleaved UART/FIR reads
    su1 = nu1; sf1 = nf1; su2 = nu2; sf2 = nf2;
    for (int k = 0; k < 6; k++) begin
      uart_mem_re = 1; uart_addr = 14'h0020 + 14'(k);
      tick();
      uart_mem_re = 0;
      fir_req = 1; fir_we = 0; fir_addr = 14'h0040 + 14'(k);
      @(posedge clk); #1;
      fir_req = 0;
      tick(); tick();
    end
    for (int k = 0; k < 6; k++) tick();
    chk("ilv.d2_uart_cnt", 32'(nu2 - su2), 6);
    chk("ilv.d2_fir_cnt", 32'(nf2 - sf2), 6);
    chk("ilv.d1_uart_cnt", 32'(nu1 - su1), 6);
    chk("ilv.d1_fir_cnt", 32'(nf1 - sf1), 6);

    // Reset one cycle after a FIR read issues
    sf1 = nf1; sf2 = nf2;
    fir_req = 1; fir_we = 0; fir_addr = 14'h0050;
    @(posedge clk); #1;
    fir_req = 0;
    arst_n = 0;
    tick(); tick();
    arst_n = 1;
    for (int k = 0; k < 6; k++) tick();
    chk("rst2.no_fir_rvalid1", 32'(nf1 - sf1), 0);
    chk("rst2.no_fir_rvalid2", 32'(nf2 - sf2), 0);
    chk("rst2.fir_gnt", 32'(gnt1), 1);
    chk("rst2.mem_en", 32'(men1), 0);
    chk("rst2.busy", 32'(busy1), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
